// File: rtl/sad_disparity_search.sv
// Stereo SAD disparity search: holds sliding left/right column windows and, per accepted column,
// scans disparities 0..MAX_DISP one per cycle, reporting best disparity, SAD, depth and confidence.
module sad_disparity_search #(
  parameter int unsigned KERNEL_WIDTH = 3,
  parameter int unsigned MAX_DISP     = 10,
  parameter int unsigned PIX_WIDTH    = 8,
  localparam int unsigned SAD_W       = PIX_WIDTH + $clog2(KERNEL_WIDTH * KERNEL_WIDTH),
  localparam int unsigned DISP_W      = $clog2(MAX_DISP + 1)
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [KERNEL_WIDTH*PIX_WIDTH-1:0] left_col_in,
  input  logic [KERNEL_WIDTH*PIX_WIDTH-1:0] right_col_in,
  input  logic [10:0]                       hcount_in,
  input  logic [9:0]                        vcount_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  input  logic                              tie_mode_in,
  input  logic [SAD_W-1:0]                  max_sad_in,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic [DISP_W-1:0]                 disparity_out,
  output logic [SAD_W-1:0]                  sad_out,
  output logic [7:0]                        depth_out,
  output logic                              confident_out,
  output logic [10:0]                       hcount_out,
  output logic [9:0]                        vcount_out
);

  localparam int unsigned RWIN   = KERNEL_WIDTH + MAX_DISP;
  localparam int unsigned FILL_W = $clog2(RWIN + 1);

  typedef enum logic [1:0] {StIdle, StSearch, StOut} state_e;
  typedef logic [KERNEL_WIDTH-1:0][PIX_WIDTH-1:0] col_t;

  state_e            state_q, state_d;
  col_t              l_q [KERNEL_WIDTH];
  col_t              r_q [RWIN];
  logic [FILL_W-1:0] fill_q;
  logic [DISP_W-1:0] d_q;
  logic              tie_q;
  logic [SAD_W-1:0]  max_sad_q;
  logic [10:0]       hcount_q;
  logic [9:0]        vcount_q;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic [DISP_W-1:0] best_disp_q, best_disp_d;
  logic [DISP_W-1:0] res_disp_q;
  logic [SAD_W-1:0]  res_sad_q;
  logic [7:0]        res_depth_q, depth_d;
  logic              res_conf_q, conf_d;

  logic              accept;
  logic              last_d;
  logic              take;
  logic [SAD_W-1:0]  sad_cur;
  logic [7:0]        depth_lut [MAX_DISP+1];

  for (genvar i = 0; i <= MAX_DISP; i++) begin : g_depth_lut
    assign depth_lut[i] = 8'((i * 255) / MAX_DISP);
  end

  assign ready_out = (state_q == StIdle);
  assign accept    = valid_in && ready_out;
  assign last_d    = (d_q == DISP_W'(MAX_DISP));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (valid_in) state_d = StSearch;
      StSearch: if (last_d) state_d = StOut;
      StOut:    if (ready_in) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // SAD between the left window and the right window offset by the current disparity.
  always_comb begin : p_sad
    logic signed [PIX_WIDTH:0] diff;
    logic [PIX_WIDTH-1:0]      absd;
    sad_cur = '0;
    diff    = '0;
    absd    = '0;
    for (int c = 0; c < KERNEL_WIDTH; c++) begin
      for (int r = 0; r < KERNEL_WIDTH; r++) begin
        diff    = $signed({1'b0, l_q[c][r]}) - $signed({1'b0, r_q[c + int'(d_q)][r]});
        absd    = diff[PIX_WIDTH] ? PIX_WIDTH'(-diff) : PIX_WIDTH'(diff);
        sad_cur = sad_cur + SAD_W'(absd);
      end
    end
  end

  // tie_q == 0 lets equal SADs at larger disparities win.
  always_comb begin
    take        = (d_q == '0) || (sad_cur < best_sad_q) || ((sad_cur == best_sad_q) && !tie_q);
    best_sad_d  = take ? sad_cur : best_sad_q;
    best_disp_d = take ? d_q : best_disp_q;
    conf_d      = (fill_q == FILL_W'(RWIN)) && (best_sad_d <= max_sad_q);
    depth_d     = conf_d ? depth_lut[best_disp_d] : 8'd0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int c = 0; c < KERNEL_WIDTH; c++) l_q[c] <= '0;
      for (int c = 0; c < RWIN; c++)         r_q[c] <= '0;
      fill_q      <= '0;
      d_q         <= '0;
      tie_q       <= 1'b0;
      max_sad_q   <= '0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      best_sad_q  <= '0;
      best_disp_q <= '0;
      res_disp_q  <= '0;
      res_sad_q   <= '0;
      res_depth_q <= '0;
      res_conf_q  <= 1'b0;
    end else if (accept) begin
      for (int c = KERNEL_WIDTH - 1; c > 0; c--) l_q[c] <= l_q[c-1];
      for (int c = RWIN - 1; c > 0; c--)         r_q[c] <= r_q[c-1];
      l_q[0]    <= left_col_in;
      r_q[0]    <= right_col_in;
      hcount_q  <= hcount_in;
      vcount_q  <= vcount_in;
      tie_q     <= tie_mode_in;
      max_sad_q <= max_sad_in;
      d_q       <= '0;
      if (hcount_in == '0) begin
        fill_q <= FILL_W'(1);
      end else if (fill_q != FILL_W'(RWIN)) begin
        fill_q <= fill_q + FILL_W'(1);
      end
    end else if (state_q == StSearch) begin
      best_sad_q  <= best_sad_d;
      best_disp_q <= best_disp_d;
      if (last_d) begin
        res_disp_q  <= best_disp_d;
        res_sad_q   <= best_sad_d;
        res_depth_q <= depth_d;
        res_conf_q  <= conf_d;
      end else begin
        d_q <= d_q + DISP_W'(1);
      end
    end
  end

  assign valid_out     = (state_q == StOut);
  assign disparity_out = res_disp_q;
  assign sad_out       = res_sad_q;
  assign depth_out     = res_depth_q;
  assign confident_out = res_conf_q;
  assign hcount_out    = hcount_q;
  assign vcount_out    = vcount_q;

endmodule

// File: tb/tb_sad_disparity_search.sv
// Bench for sad_disparity_search: table vectors, hand-written corner sequences and random columns
// checked against an exhaustive-search reference model of the window contents.
module tb_sad_disparity_search;

  localparam int KW   = 3;
  localparam int MAXD = 10;
  localparam int PW   = 8;
  localparam int RW   = KW + MAXD;
  localparam int SW   = 12;
  localparam int DW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [KW*PW-1:0] left_col, right_col;
  logic [10:0]      hcount, hcount_o;
  logic [9:0]       vcount, vcount_o;
  logic             valid_in, ready_out, tie_mode, valid_out, ready_in, confident;
  logic [SW-1:0]    max_sad, sad;
  logic [DW-1:0]    disparity;
  logic [7:0]       depth;

  sad_disparity_search dut (
    .clk_in       (clk),
    .rst_in       (rst_n),
    .left_col_in  (left_col),
    .right_col_in (right_col),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .tie_mode_in  (tie_mode),
    .max_sad_in   (max_sad),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .disparity_out(disparity),
    .sad_out      (sad),
    .depth_out    (depth),
    .confident_out(confident),
    .hcount_out   (hcount_o),
    .vcount_out   (vcount_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: raw column history (newest first) plus the fill count.
  logic [KW*PW-1:0] m_l [KW];
  logic [KW*PW-1:0] m_r [RW];
  int m_fill;
  int e_disp, e_sad, e_depth, e_hc, e_vc;
  bit e_conf;

  task automatic model_reset();
    for (int c = 0; c < KW; c++) m_l[c] = '0;
    for (int c = 0; c < RW; c++) m_r[c] = '0;
    m_fill = 0;
  endtask

  task automatic model_push(input logic [KW*PW-1:0] l, input logic [KW*PW-1:0] r, input int hc);
    for (int c = KW - 1; c > 0; c--) m_l[c] = m_l[c-1];
    for (int c = RW - 1; c > 0; c--) m_r[c] = m_r[c-1];
    m_l[0] = l;
    m_r[0] = r;
    m_fill = (hc == 0) ? 1 : ((m_fill + 1 > RW) ? RW : m_fill + 1);
  endtask

  // Compute every SAD, take the minimum, then pick the extreme disparity achieving it.
  task automatic model_eval(input bit tie, input int msad);
    int sads [MAXD+1];
    int best;
    for (int d = 0; d <= MAXD; d++) begin
      int s = 0;
      for (int c = 0; c < KW; c++) begin
        for (int r = 0; r < KW; r++) begin
          int a = int'(m_l[c][r*PW +: PW]);
          int b = int'(m_r[c+d][r*PW +: PW]);
          s += (a > b) ? a - b : b - a;
        end
      end
      sads[d] = s;
    end
    best = sads[0];
    for (int d = 1; d <= MAXD; d++) if (sads[d] < best) best = sads[d];
    e_disp = -1;
    for (int d = 0; d <= MAXD; d++) begin
      if (sads[d] == best) begin
        if (!tie) e_disp = d;
        else if (e_disp < 0) e_disp = d;
      end
    end
    e_sad   = best;
    e_conf  = (m_fill == RW) && (best <= msad);
    e_depth = e_conf ? (e_disp * 255) / MAXD : 0;
  endtask

  task automatic accept_col(input logic [KW*PW-1:0] l, input logic [KW*PW-1:0] r, input int hc,
                            input int vc, input bit tie, input int msad);
    int n = 0;
    @(negedge clk);
    left_col  = l;
    right_col = r;
    hcount    = 11'(hc);
    vcount    = 10'(vc);
    tie_mode  = tie;
    max_sad   = SW'(msad);
    valid_in  = 1'b1;
    while (!ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", ready_out, 1);
    @(posedge clk);
    #1 valid_in = 1'b0;
    model_push(l, r, hc);
    model_eval(tie, msad);
    e_hc = hc;
    e_vc = vc;
  endtask

  task automatic wait_and_check(input string tag);
    int n = 0;
    while (!valid_out && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, MAXD + 1);
    @(negedge clk);
    check({tag, "_disp"}, disparity, e_disp);
    check({tag, "_sad"}, sad, e_sad);
    check({tag, "_depth"}, depth, e_depth);
    check({tag, "_conf"}, confident, e_conf);
    check({tag, "_hcount"}, hcount_o, e_hc);
    check({tag, "_vcount"}, vcount_o, e_vc);
  endtask

  task automatic release_result(input int delay);
    repeat (delay) @(negedge clk);
    ready_in = 1'b1;
    @(posedge clk);
    #1 ready_in = 1'b0;
    check("valid_drop_after_handshake", valid_out, 0);
  endtask

  typedef struct {
    logic [KW*PW-1:0] l;
    logic [KW*PW-1:0] r;
    int               hc0;
    int               rep;
    bit               tie;
    int               msad;
    int               disp;
    int               sad;
    int               depth;
    bit               conf;
  } vec_t;

  vec_t tbl [8];
  logic [KW*PW-1:0] seq [24];

  initial begin
    logic [24:0] snap_a;
    logic [20:0] snap_b;
    int hcn;
    int rise [3];
    int edges, nr, highs;
    logic prev;

    rst_n     = 1'b0;
    valid_in  = 1'b0;
    ready_in  = 1'b0;
    left_col  = '0;
    right_col = '0;
    hcount    = '0;
    vcount    = '0;
    tie_mode  = 1'b0;
    max_sad   = '1;
    model_reset();

    // Reset state.
    #12;
    check("rst_valid_out", valid_out, 0);
    check("rst_ready_out", ready_out, 1);
    check("rst_disp", disparity, 0);
    check("rst_sad", sad, 0);
    check("rst_depth", depth, 0);
    check("rst_conf", confident, 0);
    check("rst_hcount", hcount_o, 0);
    check("rst_vcount", vcount_o, 0);
    #10 rst_n = 1'b1;

    // Confidence ramps in only once the window is full, and restarts on hcount 0.
    for (int t = 0; t < 16; t++) begin
      accept_col(24'($urandom), 24'($urandom), t, 1, 1'b0, 4095);
      wait_and_check("fill");
      check("fill_conf", confident, (t >= 12) ? 1 : 0);
      release_result(0);
    end
    for (int t = 0; t < 13; t++) begin
      accept_col(24'($urandom), 24'($urandom), t, 2, 1'b0, 4095);
      wait_and_check("refill");
      check("refill_conf", confident, (t == 12) ? 1 : 0);
      release_result(0);
    end

    // Right image leads left by 4 columns, so the true match sits at disparity 4.
    for (int t = 0; t < 24; t++) seq[t] = 24'($urandom);
    for (int t = 0; t < 20; t++) begin
      accept_col(seq[t], seq[t+4], t, 4, 1'b0, 4095);
      wait_and_check("shift4");
      if (t >= 12) begin
        check("shift4_disp", disparity, 4);
        check("shift4_sad", sad, 0);
        check("shift4_depth", depth, 102);
        check("shift4_conf", confident, 1);
      end
      release_result(0);
    end

    // Absolute-value, threshold and tie-break vectors.
    tbl[0] = '{24'hC8C8C8, 24'h000000, 0, 13, 1'b0, 4095, 10, 1800, 255, 1'b1};
    tbl[1] = '{24'hC8C8C8, 24'h000000, 13, 1, 1'b0, 1799, 10, 1800, 0, 1'b0};
    tbl[2] = '{24'hC8C8C8, 24'h000000, 14, 1, 1'b0, 1800, 10, 1800, 255, 1'b1};
    tbl[3] = '{24'hC8C8C8, 24'h000000, 15, 1, 1'b1, 1800, 0, 1800, 0, 1'b1};
    tbl[4] = '{24'h000000, 24'hC8C8C8, 16, 13, 1'b0, 4095, 10, 1800, 255, 1'b1};
    tbl[5] = '{24'h000000, 24'hC8C8C8, 29, 1, 1'b1, 1799, 0, 1800, 0, 1'b0};
    tbl[6] = '{24'h4D4D4D, 24'h4D4D4D, 0, 13, 1'b0, 4095, 10, 0, 255, 1'b1};
    tbl[7] = '{24'h4D4D4D, 24'h4D4D4D, 13, 1, 1'b1, 4095, 0, 0, 0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < tbl[i].rep; j++) begin
        accept_col(tbl[i].l, tbl[i].r, tbl[i].hc0 + j, 3, tbl[i].tie, tbl[i].msad);
        wait_and_check("tbl");
        if (j == tbl[i].rep - 1) begin
          check($sformatf("tbl%0d_disp", i), disparity, tbl[i].disp);
          check($sformatf("tbl%0d_sad", i), sad, tbl[i].sad);
          check($sformatf("tbl%0d_depth", i), depth, tbl[i].depth);
          check($sformatf("tbl%0d_conf", i), confident, tbl[i].conf);
        end
        release_result(0);
      end
    end

    // Backpressure: outputs frozen, ready_out low, valid_in pulses ignored.
    accept_col(24'($urandom), 24'($urandom), 30, 9, 1'b0, 4095);
    wait_and_check("bp");
    snap_a = {disparity, sad, depth, confident};
    snap_b = {hcount_o, vcount_o};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      valid_in  = (i % 2 == 0);
      left_col  = 24'($urandom);
      right_col = 24'($urandom);
      hcount    = 11'($urandom);
      @(negedge clk);
      check("bp_hold_result", {disparity, sad, depth, confident}, snap_a);
      check("bp_hold_counts", {hcount_o, vcount_o}, snap_b);
      check("bp_valid_out", valid_out, 1);
      check("bp_ready_out", ready_out, 0);
    end
    valid_in = 1'b0;
    release_result(0);
    @(negedge clk);
    check("bp_ready_after", ready_out, 1);

    // Random columns against the model; a skipped or extra shift would show up here.
    hcn = 31;
    for (int i = 0; i < 30; i++) begin
      hcn = ($urandom_range(0, 9) == 0) ? 0 : hcn + 1;
      accept_col(24'($urandom), 24'($urandom), hcn, int'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2500)));
      wait_and_check("rand");
      release_result(int'($urandom_range(0, 3)));
    end

    // Streaming: valid_in and ready_in held high.
    @(negedge clk);
    left_col  = 24'h102030;
    right_col = 24'h405060;
    hcount    = 11'd1;
    valid_in  = 1'b1;
    ready_in  = 1'b1;
    for (int i = 0; i < 3; i++) rise[i] = -1;
    edges = 0;
    nr    = 0;
    prev  = 1'b0;
    while (nr < 3 && edges < 80) begin
      @(posedge clk);
      #1;
      edges++;
      if (valid_out && !prev) begin
        rise[nr] = edges;
        nr++;
      end
      prev = valid_out;
    end
    check("stream_first_valid_edge", rise[0], 12);
    check("stream_period_1", rise[1] - rise[0], 13);
    check("stream_period_2", rise[2] - rise[1], 13);

    // Reset in the middle of a search.
    repeat (4) @(posedge clk);
    #1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_valid_out", valid_out, 0);
    check("midrst_ready_out", ready_out, 1);
    check("midrst_sad", sad, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (valid_out) highs++;
    end
    check("midrst_no_result", highs, 0);
    accept_col(24'hFFFFFF, 24'hFFFFFF, 5, 6, 1'b0, 4095);
    wait_and_check("postrst");
    check("postrst_conf", confident, 0);
    release_result(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sad_disparity_search.md
Name: sad_disparity_search

Overview:
- Parametrised successor to the stereo SAD matcher. Accepts one KERNEL_WIDTH-tall pixel column per image per transaction and holds sliding left and right windows.
- For each accepted column it searches disparities 0..MAX_DISP, one per cycle, using true absolute differences. It emits the best disparity, its SAD, an 8-bit relative depth and a confidence flag.
- Valid/ready on both sides. Sits between the line-buffer column extractor and the depth-map frame writer.

Parameters:
- KERNEL_WIDTH, 3, window is KERNEL_WIDTH x KERNEL_WIDTH pixels.
- MAX_DISP, 10, largest disparity searched, in columns; must be >= 1.
- PIX_WIDTH, 8, bits per grayscale pixel.
- Derived: SAD_W = PIX_WIDTH + $clog2(KERNEL_WIDTH*KERNEL_WIDTH); DISP_W = $clog2(MAX_DISP+1).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; asynchronous, active-low.
- left_col_in  in  KERNEL_WIDTH*PIX_WIDTH  left column, row 0 in LSBs.
- right_col_in  in  KERNEL_WIDTH*PIX_WIDTH  right column, same packing.
- hcount_in  in  11  column x of the input column.
- vcount_in  in  10  row y of the input column.
- valid_in  in  1  input column valid.
- ready_out  out  1  block can accept a column.
- tie_mode_in  in  1  0: equal SAD prefers larger disparity; 1: prefers smaller.
- max_sad_in  in  SAD_W  confidence threshold.
- valid_out  out  1  result valid.
- ready_in  in  1  downstream accepts result.
- disparity_out  out  DISP_W  best disparity.
- sad_out  out  SAD_W  SAD at best disparity.
- depth_out  out  8  relative depth.
- confident_out  out  1  result trustworthy.
- hcount_out  out  11  x of the accepted column.
- vcount_out  out  10  y of the accepted column.

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; caches, fill counter and all result registers cleared.
  - valid_out=0, disparity_out=0, sad_out=0, depth_out=0, confident_out=0, hcount_out=0, vcount_out=0.
  - ready_out=1, but no transfer occurs while rst_in is low.
  - Reset asserted mid-SEARCH or mid-OUT aborts the search and drops the result.
- Caches: left window L holds KERNEL_WIDTH columns; right window R holds KERNEL_WIDTH+MAX_DISP columns. Column index 0 is the newest in both.
- Accept: transfer happens when valid_in && ready_out. ready_out = (state==IDLE).
  - On accept, both caches shift by one column and the new columns enter index 0.
  - hcount_in, vcount_in, tie_mode_in and max_sad_in are latched.
  - fill counter: set to 1 if hcount_in==0, otherwise increments, saturating at KERNEL_WIDTH+MAX_DISP.
  - State moves to SEARCH with d=0.
- SEARCH: each cycle computes SAD(d) = sum over c<KERNEL_WIDTH, r<KERNEL_WIDTH of |L[c][r] - R[c+d][r]|.
  - Each difference is taken at PIX_WIDTH+1 bits signed, then converted to absolute value. The sum is SAD_W bits and never overflows.
  - Best-result update rules:
    - d=0 always loads the best registers.
    - d>0 replaces the best if SAD < best.
    - d>0 also replaces the best if SAD == best and the latched tie_mode is 0.
  - After d==MAX_DISP the state moves to OUT.
- OUT: valid_out=1; all outputs held stable until ready_in.
  - On valid_out && ready_in the state returns to IDLE and valid_out drops the next cycle.
  - No accept occurs in the same cycle as the OUT handshake.
- Latency: valid_out rises MAX_DISP+1 clock edges after the accepting edge (11 edges at default parameters).
  - Throughput with ready_in tied high and valid_in held high: one result per MAX_DISP+3 cycles (13 at default).
- confident_out = (fill == KERNEL_WIDTH+MAX_DISP) && (best SAD <= latched max_sad_in).
- depth_out = floor(disparity*255/MAX_DISP), from an elaboration-time constant table. Default table: 0,25,51,76,102,127,153,178,204,229,255.
  - depth_out is forced to 0 when confident_out=0.
  - disparity_out and sad_out are always reported.
- hcount_out / vcount_out echo the latched counts of the accepted column.
- Caches are not cleared at line start; only the fill counter restarts, so stale columns are masked by confident_out=0.

Test Plan:
1. Textured random rows; right = left shifted so a true match sits 4 columns older; default parameters; max_sad_in all-ones; after a full warm-up -> disparity_out=4, sad_out=0, depth_out=102, confident_out=1.
2. Reset release, then 13 columns with hcount 0..12 -> columns 0..11 give confident_out=0 and depth_out=0; column 12 gives confident_out=1. A later column with hcount_in=0 restarts the count and clears confident_out for the next 12 columns.
3. Absolute value and threshold: left all 200, right all 0 -> sad_out=1800 for every d. Swapping to left 0, right 200 also gives 1800. max_sad_in=1799 -> confident_out=0, depth_out=0; max_sad_in=1800 -> confident_out=1.
4. Ties: identical flat images after warm-up -> tie_mode_in=0 gives disparity_out=10, depth_out=255; tie_mode_in=1 gives disparity_out=0, depth_out=0.
5. Backpressure: ready_in low for 5 cycles during OUT -> all outputs bit-stable, ready_out=0, valid_in pulses ignored. Raising ready_in completes the transfer and ready_out=1 on the following cycle.
6. Timing and reset: valid_in and ready_in held high -> first valid_out 11 edges after accept, then one pulse every 13 cycles. Asserting rst_in low mid-SEARCH -> valid_out=0 immediately, no result emitted after release, and the fill counter restarts.
